plab4_net_router_credit_out_arb: RTL

//  Credit-based output-port controller for the 3-port ring router.
//  - Round-robin arbitration between the three input controls (in0/in1/in2) competing for one output.
//  - Sequences the crossbar select for that output.
//  - Replaces the out_rdy handshake with a downstream credit counter.
//  - Exports the credit count so adaptive input controls can steer traffic, as they do with num_free_*.

---
 rtl/plab4_net_router_credit_out_arb.sv | 96 +++++++++
 1 files changed

// File: rtl/plab4_net_router_credit_out_arb.sv
// rtl/plab4_net_router_credit_out_arb.sv - credit-based round-robin output-port controller
//
// Purpose: arbitrates among the three router input controls for one output,
// drives the crossbar select, and tracks downstream queue space with a credit
// counter in place of an out_rdy handshake.
//
// Ports:
//   clk          clock, all state updates on posedge
//   reset        asynchronous active-low reset (0 = in reset)
//   reqs         requests from input controls, bit i = input i
//   grants       one-hot (or zero) grant back to input controls
//   out_val      crossbar output carries a valid message
//   xbar_sel     index of the granted input, 0 when no grant
//   credit_ret   downstream dequeued one entry, returns one credit
//   num_credits  current credit count (registered)
//   credit_err   sticky: credit returned while the counter was already full

module plab4_net_router_credit_out_arb #(
  parameter int p_num_credits  = 4,
  parameter int p_credit_nbits = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                reqs,
  output logic [2:0]                grants,
  output logic                      out_val,
  output logic [1:0]                xbar_sel,
  input  logic                      credit_ret,
  output logic [p_credit_nbits-1:0] num_credits,
  output logic                      credit_err
);

  localparam logic [p_credit_nbits-1:0] max_credits = p_credit_nbits'(p_num_credits);

  logic [p_credit_nbits-1:0] credits;
  logic [2:0]                prio;
  logic                      err;

  // Priority scan starts at the one-hot prio position and wraps 2->0.
  // Gating on reset keeps outputs quiet while the async clear is held, and
  // gating on credits keeps any message from being sent without space.
  always_comb begin
    grants = 3'b000;
    if (reset && (credits != '0)) begin
      unique case (prio)
        3'b010: begin
          if      (reqs[1]) grants = 3'b010;
          else if (reqs[2]) grants = 3'b100;
          else if (reqs[0]) grants = 3'b001;
        end
        3'b100: begin
          if      (reqs[2]) grants = 3'b100;
          else if (reqs[0]) grants = 3'b001;
          else if (reqs[1]) grants = 3'b010;
        end
        default: begin
          if      (reqs[0]) grants = 3'b001;
          else if (reqs[1]) grants = 3'b010;
          else if (reqs[2]) grants = 3'b100;
        end
      endcase
    end
  end

  always_comb begin
    out_val = |grants;
    if (grants[1])      xbar_sel = 2'd1;
    else if (grants[2]) xbar_sel = 2'd2;
    else                xbar_sel = 2'd0;
  end

  assign num_credits = credits;
  assign credit_err  = err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits <= max_credits;
      prio    <= 3'b001;
      err     <= 1'b0;
    end else begin
      // Rotate only on an actual grant: the winner drops to lowest priority.
      if (grants[0])      prio <= 3'b010;
      else if (grants[1]) prio <= 3'b100;
      else if (grants[2]) prio <= 3'b001;

      // A send consumes a credit; a return restores one; both together cancel.
      if (out_val && !credit_ret) begin
        credits <= credits - 1'b1;
      end else if (credit_ret && !out_val) begin
        if (credits == max_credits) err <= 1'b1;
        else                        credits <= credits + 1'b1;
      end
    end
  end

endmodule
